// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the CPU-side request/response handshake and the memory data port
//   of the load/store unit into a single interface.
//
//   Signals
//     req_valid  : request present (CPU -> LSU)
//     req_ready  : LSU can accept a request (LSU -> CPU)
//     req_we     : 1 = store, 0 = load
//     req_size   : 00 byte, 01 half, 10 word, 11 illegal
//     req_signed : sign-extend a sub-word load
//     req_addr   : byte address
//     req_wdata  : right-aligned store data
//     rsp_valid  : one-cycle response pulse
//     rsp_rdata  : load result (0 for stores and errors)
//     rsp_err    : request rejected, qualified by rsp_valid
//     mem_addr   : word-aligned memory address
//     mem_wdata  : memory write data
//     mem_rdata  : memory read data, combinational from mem_addr
//     mem_wr_en  : memory write enable
//
//   Modports
//     slave  : the load/store unit itself
//     master : the environment around it (CPU control FSM plus memory)
// -----------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_wr_en
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wdata, mem_wr_en
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sequences one load or store at a time from the CPU datapath into the
//   unified 16 KiB word-addressed memory. Byte and halfword stores are done
//   as read-modify-write because the memory only writes whole words. Loads
//   are sign- or zero-extended. Misaligned or out-of-range requests are
//   rejected with an error response and never touch memory.
//
//   Ports
//     clk   : system clock, all state updates on the rising edge
//     rst_n : synchronous active-low reset
//     bus   : request/response handshake and memory data port
//             (see load_store_unit_if)
//
//   Sequence per request
//     IDLE -> RESP                       illegal request (1 edge)
//     IDLE -> ACCESS -> RESP             load or word store (2 edges)
//     IDLE -> ACCESS -> WRITE -> RESP    byte/half store (3 edges)
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state_q;
  state_t state_d;

  // Latched request
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;

  // Load result and RMW merged word
  logic [31:0] result_q;
  logic [31:0] merged_q;

  logic        accept;
  logic        req_illegal;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // ---------------------------------------------------------------------------
  // Request legality, evaluated on the live request in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    req_illegal = 1'b0;
    if (|bus.req_addr[31:14]) begin
      req_illegal = 1'b1;
    end
    case (bus.req_size)
      SZ_BYTE: ;
      SZ_HALF: if (bus.req_addr[0])        req_illegal = 1'b1;
      SZ_WORD: if (|bus.req_addr[1:0])     req_illegal = 1'b1;
      default: req_illegal = 1'b1;
    endcase
  end

  assign accept = (state_q == IDLE) && bus.req_valid;

  // ---------------------------------------------------------------------------
  // Lane extraction / extension for loads, lane merge for sub-word stores.
  // Little-endian: byte k lives at bits [8k+7:8k], half h at [16h+15:16h].
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_lane = bus.mem_rdata[7:0];
      2'd1:    byte_lane = bus.mem_rdata[15:8];
      2'd2:    byte_lane = bus.mem_rdata[23:16];
      default: byte_lane = bus.mem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    case (size_q)
      SZ_BYTE: load_ext = signed_q ? {{24{byte_lane[7]}}, byte_lane}
                                   : {24'h000000, byte_lane};
      SZ_HALF: load_ext = signed_q ? {{16{half_lane[15]}}, half_lane}
                                   : {16'h0000, half_lane};
      default: load_ext = bus.mem_rdata;
    endcase

    // Sub-word store: clear the target lane of the current word and OR in
    // the right-aligned store data shifted into place.
    if (size_q == SZ_HALF) begin
      shift     = {addr_q[1], 4'b0000};
      lane_mask = 32'h0000_FFFF << shift;
    end else begin
      shift     = {addr_q[1:0], 3'b000};
      lane_mask = 32'h0000_00FF << shift;
    end
    lane_data = wdata_q << shift;
    merged    = (bus.mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the pre-edge values of its neighbours.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.req_valid) state_d = req_illegal ? RESP : ACCESS;
      ACCESS: state_d = (we_q && (size_q != SZ_WORD)) ? WRITE : RESP;
      WRITE:  state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: request latch, load result, merged word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is cleared on reset, not just the FSM, so that
    // mem_addr and the response fields come out of reset at a defined 0.
    if (!rst_n) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      result_q <= 32'h0;
      merged_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q     <= bus.req_we;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            err_q    <= req_illegal;
            // Stores and errors respond with zero data.
            result_q <= 32'h0;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            result_q <= load_ext;
          end else begin
            merged_q <= merged;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Handshake strobes are forced low while rst_n is asserted so
  // a reset in ACCESS or WRITE cannot leak a write or a response.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = 32'h0;
    bus.mem_addr  = {addr_q[31:2], 2'b00};
    bus.mem_wdata = (state_q == WRITE) ? merged_q : wdata_q;

    case (state_q)
      IDLE:   bus.req_ready = rst_n;
      ACCESS: bus.mem_wr_en = rst_n && we_q && (size_q == SZ_WORD);
      WRITE:  bus.mem_wr_en = rst_n;
      RESP: begin
        bus.rsp_valid = rst_n;
        bus.rsp_err   = rst_n && err_q;
        bus.rsp_rdata = rst_n ? result_q : 32'h0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk;
  logic rst_n;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory model: 4096 words, combinational read, write on the rising edge.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:4095];

  assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Counters and checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int          base;
  } exp_t;

  exp_t sb[$];

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per response pulse.
  // ---------------------------------------------------------------------------
  int wr_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wr_cnt = 0;
    end else begin
      if (bus.mem_wr_en) begin
        wr_cnt++;
        check("ready_low_during_write", {31'b0, bus.req_ready}, 32'h0);
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp_valid", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
          check("rsp_latency", cyc - e.base, e.lat);
          check("write_count", wr_cnt, e.nwr);
          check("ready_low_in_resp", {31'b0, bus.req_ready}, 32'h0);
        end
        wr_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_wr, input bit keep_valid);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'h0, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.nwr   = exp_wr;
    e.base  = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hFFFF_FFFF;
      bus.req_wdata = 32'hA5A5_A5A5;
    end
    for (int i = 0; i < exp_lat; i++) begin
      @(negedge clk);
      check("ready_busy", {31'b0, bus.req_ready}, 32'h0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("response_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'h0);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("reset_mem_wr_en", {31'b0, bus.mem_wr_en}, 32'h0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, bus.req_ready}, 32'h1);

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1'b0);
    drain();

    // Byte store RMW
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FF7F, 32'h0, 1'b0, 3, 1, 1'b0);
    drain();
    check("mem_after_byte_store", mem[12'h040], 32'hDEAD7FEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD7FEF, 1'b0, 2, 0, 1'b0);
    drain();

    // Sub-word loads with extension
    mem[12'h044] = 32'h80AB_CDEF;
    do_req(1'b0, 2'b00, 1'b1, 32'h113, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h113, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h112, 32'h0, 32'hFFFF_80AB, 1'b0, 2, 0, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h110, 32'h0, 32'h0000_CDEF, 1'b0, 2, 0, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h111, 32'h0, 32'hFFFF_FFCD, 1'b0, 2, 0, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h110, 32'h0, 32'hFFFF_CDEF, 1'b0, 2, 0, 1'b0);
    drain();

    // Half store RMW into the upper half
    do_req(1'b1, 2'b01, 1'b0, 32'h112, 32'hAAAA_1234, 32'h0, 1'b0, 3, 1, 1'b0);
    drain();
    check("mem_after_half_store", mem[12'h044], 32'h1234_CDEF);

    // Illegal requests
    do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h4000, 32'h1357_9BDF, 32'h0, 1'b1, 1, 0, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000_BEEF, 32'h0, 1'b1, 1, 0, 1'b0);
    drain();
    check("mem_untouched_by_error", mem[12'h000], 32'h0);
    check("mem_untouched_by_half_err", mem[12'h040], 32'hDEAD7FEF);

    // Back-to-back with req_valid held high
    do_req(1'b1, 2'b10, 1'b0, 32'h300, 32'h55AA_00FF, 32'h0, 1'b0, 2, 1, 1'b1);
    do_req(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 32'h0000_00AA, 1'b0, 2, 0, 1'b1);
    do_req(1'b1, 2'b00, 1'b1, 32'h303, 32'h0000_009C, 32'h0, 1'b0, 3, 1, 1'b1);
    do_req(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'hFFFF_9CAA, 1'b0, 2, 0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 32'h0, 1'b1, 1, 0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h9CAA_00FF, 1'b0, 2, 0, 1'b0);
    drain();

    // Reset during ACCESS of a byte store
    mem[12'h080] = 32'h1122_3344;
    @(negedge clk);
    check("ready_before_rst_test", {31'b0, bus.req_ready}, 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h200;
    bus.req_wdata  = 32'h0000_00AB;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_forces_wr_en", {31'b0, bus.mem_wr_en}, 32'h0);
    check("rst_forces_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("rst_forces_req_ready", {31'b0, bus.req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_first_cycle_after_rst", {31'b0, bus.req_ready}, 32'h1);
    check("mem_addr_cleared", bus.mem_addr, 32'h0);
    repeat (4) @(negedge clk);
    check("mem_unchanged_after_rst", mem[12'h080], 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
